// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the EX-stage branch resolution block: BHT counter
// states, resolver FSM states and the sequential-PC increment.
package branch_resolve_pkg;

   // 2-bit saturating predictor counter states
   typedef enum logic [1:0] {
      BHT_SNT = 2'd0,
      BHT_WNT = 2'd1,
      BHT_WT  = 2'd2,
      BHT_ST  = 2'd3
   } bht_ctr_e;

   // Resolver FSM: REDIRECT is the one-cycle window where the redirect is driven
   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } br_state_e;

   localparam logic [31:0] PC_INC = 32'd4;

   // Counter value every entry returns to on reset
   localparam bht_ctr_e BHT_RESET_VAL = BHT_WNT;

   // Saturating step towards taken (increment) or not-taken (decrement)
   function automatic bht_ctr_e bht_sat_update(input bht_ctr_e ctr, input logic taken);
      bht_ctr_e nxt;
      nxt = ctr;
      unique case (ctr)
         BHT_SNT: nxt = taken ? BHT_WNT : BHT_SNT;
         BHT_WNT: nxt = taken ? BHT_WT  : BHT_SNT;
         BHT_WT:  nxt = taken ? BHT_ST  : BHT_WNT;
         BHT_ST:  nxt = taken ? BHT_ST  : BHT_WT;
         default: nxt = BHT_RESET_VAL;
      endcase
      return nxt;
   endfunction

   // A counter predicts taken in either of its two upper states
   function automatic logic bht_predict(input bht_ctr_e ctr);
      return (ctr == BHT_WT) || (ctr == BHT_ST);
   endfunction

endpackage

// File: rtl/bht_counter_table.sv
// Branch history table: 2^IDX_BITS two-bit saturating counters with one
// combinational read port and one synchronous update port.
module bht_counter_table
   import branch_resolve_pkg::*;
#(
   parameter int unsigned IDX_BITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IDX_BITS-1:0] i_rd_idx,
   output bht_ctr_e            o_rd_ctr,
   input  logic                i_wr_en,
   input  logic [IDX_BITS-1:0] i_wr_idx,
   input  logic                i_wr_taken
);

   localparam int unsigned ENTRIES = 1 << IDX_BITS;

   bht_ctr_e r_ctr [ENTRIES];

   // Counter storage: reset all to weakly not-taken, else apply one update
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_ctr[i] <= BHT_RESET_VAL;
         end
      end else if (i_wr_en) begin
         r_ctr[i_wr_idx] <= bht_sat_update(r_ctr[i_wr_idx], i_wr_taken);
      end
   end

   // Read sees the registered value, so a same-cycle update is not forwarded
   always_comb begin
      o_rd_ctr = r_ctr[i_rd_idx];
   end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage conditional branch resolution: checks the carried prediction
// against the compare result, issues a one-cycle redirect/flush on a
// mispredict, trains the BHT and keeps resolve/mispredict statistics.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int unsigned BHT_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_valid,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_target,
   input  logic        br_pred_taken,
   input  logic        cmp_s,
   input  logic [31:0] if_pc,
   output logic        if_pred_taken,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic [15:0] br_count,
   output logic [15:0] mispred_count
);

   br_state_e   r_state;
   br_state_e   w_state_nxt;
   logic [31:0] r_redirect_pc;
   logic [15:0] r_br_count;
   logic [15:0] r_mispred_count;

   logic        w_shadow;
   logic        w_resolve;
   logic        w_mispred;
   logic [31:0] w_fix_pc;
   bht_ctr_e    w_if_ctr;

   // Branch qualification: wrong-path branches in the redirect cycle are dropped
   always_comb begin
      w_shadow  = (r_state == ST_REDIRECT);
      w_resolve = br_valid && !stall && !w_shadow;
      w_mispred = w_resolve && (cmp_s != br_pred_taken);
      w_fix_pc  = cmp_s ? br_target : (br_pc + PC_INC);
   end

   bht_counter_table #(
      .IDX_BITS (BHT_BITS)
   ) u_bht (
      .clk        (clk),
      .reset      (reset),
      .i_rd_idx   (if_pc[BHT_BITS+1:2]),
      .o_rd_ctr   (w_if_ctr),
      .i_wr_en    (w_resolve),
      .i_wr_idx   (br_pc[BHT_BITS+1:2]),
      .i_wr_taken (cmp_s)
   );

   // Fetch-side prediction straight from the table
   always_comb begin
      if_pred_taken = bht_predict(w_if_ctr);
   end

   // FSM state register; stall freezes a pending redirect
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else if (!stall) begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: redirect lasts one non-stalled cycle
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:     w_state_nxt = w_mispred ? ST_REDIRECT : ST_IDLE;
         ST_REDIRECT: w_state_nxt = ST_IDLE;
         default:     w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      redirect_valid = (r_state == ST_REDIRECT);
      flush          = redirect_valid;
      redirect_pc    = r_redirect_pc;
   end

   // Corrected PC is captured only on a mispredict and held otherwise
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_redirect_pc <= '0;
      end else if (w_mispred) begin
         r_redirect_pc <= w_fix_pc;
      end
   end

   // Statistics counters, wrapping naturally at 16 bits
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_br_count      <= '0;
         r_mispred_count <= '0;
      end else begin
         if (w_resolve) begin
            r_br_count <= r_br_count + 16'd1;
         end
         if (w_mispred) begin
            r_mispred_count <= r_mispred_count + 16'd1;
         end
      end
   end

   // Counter outputs
   always_comb begin
      br_count      = r_br_count;
      mispred_count = r_mispred_count;
   end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: hand-computed vectors checked with
// immediate assertions after each rising edge.
module tb_branch_resolve;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        br_valid;
   logic [31:0] br_pc;
   logic [31:0] br_target;
   logic        br_pred_taken;
   logic        cmp_s;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic [15:0] br_count;
   logic [15:0] mispred_count;

   int n_checks = 0;
   int n_errors = 0;

   branch_resolve #(
      .BHT_BITS (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .br_valid       (br_valid),
      .br_pc          (br_pc),
      .br_target      (br_target),
      .br_pred_taken  (br_pred_taken),
      .cmp_s          (cmp_s),
      .if_pc          (if_pc),
      .if_pred_taken  (if_pred_taken),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .br_count       (br_count),
      .mispred_count  (mispred_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic branch(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic s);
      br_valid      = 1'b1;
      br_pc         = pc;
      br_target     = tgt;
      br_pred_taken = pred;
      cmp_s         = s;
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; br_valid = 1'b0; br_pc = '0; br_target = '0;
      br_pred_taken = 1'b0; cmp_s = 1'b0; if_pc = 32'h40;
      tick(); tick();
      reset = 1'b1;

      // Reset state
      check("rst_rv",    {31'd0, redirect_valid}, 32'd0);
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_rpc",   redirect_pc, 32'd0);
      check("rst_bc",    {16'd0, br_count}, 32'd0);
      check("rst_mc",    {16'd0, mispred_count}, 32'd0);
      check("rst_pred",  {31'd0, if_pred_taken}, 32'd0);

      // Mispredict, actually taken -> redirect to target
      branch(32'h100, 32'h200, 1'b0, 1'b1);
      tick();
      br_valid = 1'b0;
      if_pc = 32'h100;
      check("m1_rv",   {31'd0, redirect_valid}, 32'd1);
      check("m1_flush", {31'd0, flush}, 32'd1);
      check("m1_rpc",  redirect_pc, 32'h200);
      check("m1_bc",   {16'd0, br_count}, 32'd1);
      check("m1_mc",   {16'd0, mispred_count}, 32'd1);
      check("m1_pred", {31'd0, if_pred_taken}, 32'd1);
      tick();
      check("m1_drop", {31'd0, redirect_valid}, 32'd0);
      check("m1_hold", redirect_pc, 32'h200);

      // Mispredict, not taken at top of memory -> fall-through wraps to 0
      branch(32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b0);
      tick();
      br_valid = 1'b0;
      check("wrap_rv",  {31'd0, redirect_valid}, 32'd1);
      check("wrap_rpc", redirect_pc, 32'h0);
      check("wrap_mc",  {16'd0, mispred_count}, 32'd2);
      tick();

      // Correct prediction: no redirect
      branch(32'h80, 32'h300, 1'b1, 1'b1);
      tick();
      br_valid = 1'b0;
      check("ok_rv", {31'd0, redirect_valid}, 32'd0);
      check("ok_bc", {16'd0, br_count}, 32'd3);
      check("ok_mc", {16'd0, mispred_count}, 32'd2);

      // Back-to-back mispredicts: second is in the shadow and ignored
      branch(32'h200, 32'h500, 1'b0, 1'b1);
      tick();
      branch(32'h308, 32'h700, 1'b0, 1'b1);
      if_pc = 32'h308;
      check("sh_rv1", {31'd0, redirect_valid}, 32'd1);
      check("sh_rpc", redirect_pc, 32'h500);
      tick();
      br_valid = 1'b0;
      check("sh_rv2",  {31'd0, redirect_valid}, 32'd0);
      check("sh_rpc2", redirect_pc, 32'h500);
      check("sh_bc",   {16'd0, br_count}, 32'd4);
      check("sh_mc",   {16'd0, mispred_count}, 32'd3);
      check("sh_bht",  {31'd0, if_pred_taken}, 32'd0);
      tick();
      check("sh_rv3", {31'd0, redirect_valid}, 32'd0);

      // Fresh reset, then train entry 0 via br_pc=0x40
      reset = 1'b0;
      tick();
      reset = 1'b1;
      if_pc = 32'h40;
      check("r2_pred", {31'd0, if_pred_taken}, 32'd0);
      branch(32'h40, 32'h80, 1'b1, 1'b1);
      check("tr_same", {31'd0, if_pred_taken}, 32'd0);
      tick();
      check("tr_1", {31'd0, if_pred_taken}, 32'd1);
      tick();
      check("tr_2", {31'd0, if_pred_taken}, 32'd1);
      tick();
      tick();
      br_valid = 1'b0;
      check("tr_4",    {31'd0, if_pred_taken}, 32'd1);
      check("tr_bc",   {16'd0, br_count}, 32'd4);
      check("tr_mc",   {16'd0, mispred_count}, 32'd0);
      // One not-taken step from saturated taken still predicts taken
      branch(32'h40, 32'h80, 1'b1, 1'b0);
      tick();
      br_valid = 1'b0;
      check("tr_dec", {31'd0, if_pred_taken}, 32'd1);
      check("tr_dec_mc", {16'd0, mispred_count}, 32'd1);
      tick();

      // Stalled resolve at entry 1 does nothing
      branch(32'h44, 32'h90, 1'b0, 1'b1);
      stall = 1'b1;
      if_pc = 32'h44;
      tick();
      stall = 1'b0;
      br_valid = 1'b0;
      check("st_rv",   {31'd0, redirect_valid}, 32'd0);
      check("st_bc",   {16'd0, br_count}, 32'd5);
      check("st_mc",   {16'd0, mispred_count}, 32'd1);
      check("st_bht",  {31'd0, if_pred_taken}, 32'd0);

      // Mispredict then 3 stalled cycles: redirect held 4 cycles
      branch(32'h500, 32'h900, 1'b0, 1'b1);
      tick();
      br_valid = 1'b0;
      stall = 1'b1;
      check("hold_0", {31'd0, redirect_valid}, 32'd1);
      tick();
      check("hold_1", {31'd0, redirect_valid}, 32'd1);
      tick();
      check("hold_2", {31'd0, redirect_valid}, 32'd1);
      tick();
      stall = 1'b0;
      check("hold_3", {31'd0, flush}, 32'd1);
      check("hold_rpc", redirect_pc, 32'h900);
      tick();
      check("hold_end", {31'd0, redirect_valid}, 32'd0);
      check("hold_bc",  {16'd0, br_count}, 32'd6);
      check("hold_mc",  {16'd0, mispred_count}, 32'd2);

      // Reset during a stalled redirect, with a simultaneous branch
      branch(32'h600, 32'hA00, 1'b0, 1'b1);
      tick();
      stall = 1'b1;
      if_pc = 32'h40;
      check("rr_rv", {31'd0, redirect_valid}, 32'd1);
      tick();
      reset = 1'b0;
      tick();
      check("rr_rv0",  {31'd0, redirect_valid}, 32'd0);
      check("rr_fl0",  {31'd0, flush}, 32'd0);
      check("rr_rpc",  redirect_pc, 32'd0);
      check("rr_bc",   {16'd0, br_count}, 32'd0);
      check("rr_mc",   {16'd0, mispred_count}, 32'd0);
      check("rr_bht",  {31'd0, if_pred_taken}, 32'd0);
      reset = 1'b1;
      stall = 1'b0;
      br_valid = 1'b0;
      tick();
      check("rr_idle", {31'd0, redirect_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
